io_port_bank: RTL

Sixteen-port nibble I/O bank for the Nibbler processor, placed directly downstream of the registered 4-to-16 port-select decoder.

- **OUT operation:** the one-hot select from the decoder steers the accumulator nibble into one of 16 output latches and raises that port's strobe. The strobe is held until the external device acknowledges it.
- **IN operation:** the same select picks one of 16 synchronized input nibbles and returns it to the datapath with a one-cycle valid pulse.
- **Errors:** protocol violations raise a sticky error flag.

---
 rtl/io_port_bank_if.sv | 28 ++
 rtl/io_port_bank.sv | 103 ++++++++++
 2 files changed

// File: rtl/io_port_bank_if.sv
// Port-bank bus: select/data from the datapath, strobed outputs, raw input pins.
// master drives sel/dir/wdata/out_ack/in_port/err_clr; slave is the bank itself.
interface io_port_bank_if #(
    parameter int P = 16,
    parameter int W = 4
);
    logic [P-1:0]   sel;
    logic           dir;
    logic [W-1:0]   wdata;
    logic [W-1:0]   rdata;
    logic           rvalid;
    logic [P*W-1:0] out_port;
    logic [P-1:0]   out_stb;
    logic [P-1:0]   out_ack;
    logic [P*W-1:0] in_port;
    logic           err;
    logic           err_clr;

    modport master (
        output sel, dir, wdata, out_ack, in_port, err_clr,
        input  rdata, rvalid, out_port, out_stb, err
    );

    modport slave (
        input  sel, dir, wdata, out_ack, in_port, err_clr,
        output rdata, rvalid, out_port, out_stb, err
    );
endinterface

// File: rtl/io_port_bank.sv
// Sixteen-port nibble I/O bank: one-hot select steers OUT writes into strobed
// latches and IN reads from 2-flop synchronized pins; sticky protocol error.
// Ports: clk, reset (async, active-high), bus (io_port_bank_if.slave).
module io_port_bank #(
    parameter int P = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    io_port_bank_if.slave  bus
);
    logic [P*W-1:0] r_sync1;
    logic [P*W-1:0] r_sync2;
    logic [P*W-1:0] r_out;
    logic [P-1:0]   r_stb;
    logic [W-1:0]   r_rdata;
    logic           r_rvalid;
    logic           r_err;

    logic           w_any;
    logic           w_multi;
    logic           w_one;
    logic [P-1:0]   w_wr;
    logic           w_ovw;
    logic           w_rd;
    logic           w_new_err;
    logic [W-1:0]   w_rmux;

    // sel & (sel-1) clears the lowest set bit; anything left means multi-hot
    assign w_any     = |bus.sel;
    assign w_multi   = |(bus.sel & (bus.sel - P'(1)));
    assign w_one     = w_any & ~w_multi;
    assign w_wr      = {P{w_one & bus.dir}} & bus.sel;
    assign w_rd      = w_one & ~bus.dir;
    // a write with a same-cycle ack is a clean handoff, not an overwrite
    assign w_ovw     = |(w_wr & r_stb & ~bus.out_ack);
    assign w_new_err = w_multi | w_ovw;

    // OR-mux is exact because it is only used when sel is one-hot
    always_comb begin
        w_rmux = '0;
        for (int i = 0; i < P; i++) begin
            if (bus.sel[i]) begin
                w_rmux = w_rmux | r_sync2[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_stb <= '0;
        end else begin
            for (int i = 0; i < P; i++) begin
                if (w_wr[i]) begin
                    r_out[i*W +: W] <= bus.wdata;
                    r_stb[i]        <= 1'b1;
                end else if (r_stb[i] && bus.out_ack[i]) begin
                    r_stb[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rmux;
            end
        end
    end

    // a fresh error outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_new_err) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;
    assign bus.out_port = r_out;
    assign bus.out_stb  = r_stb;
    assign bus.err      = r_err;
endmodule
